// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: packed entry layout, uop type and
// exception encodings, plus a helper that recognises bubble entries.
package issue_queue_pkg;

    localparam int UOP_W  = 8;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 32;
    localparam int EXC_W  = 7;
    localparam int ADDR_W = 32;

    // Entry layout, LSB first: uop, rj, rk, rd, imm, exception, badv, pc, pc_next
    localparam int UOP_LSB     = 0;
    localparam int RJ_LSB      = UOP_LSB + UOP_W;
    localparam int RK_LSB      = RJ_LSB + REG_W;
    localparam int RD_LSB      = RK_LSB + REG_W;
    localparam int IMM_LSB     = RD_LSB + REG_W;
    localparam int EXC_LSB     = IMM_LSB + IMM_W;
    localparam int BADV_LSB    = EXC_LSB + EXC_W;
    localparam int PC_LSB      = BADV_LSB + ADDR_W;
    localparam int PC_NEXT_LSB = PC_LSB + ADDR_W;
    localparam int ENTRY_W     = PC_NEXT_LSB + ADDR_W;

    localparam int UOP_TYPE_LSB  = 4;
    localparam int UOP_TYPE_MSB  = 7;
    localparam int ITYPE_IDX_ALU = 4;

    localparam logic [EXC_W-1:0] EXP_INT = 7'h40;

    function automatic logic isBubble(input logic [ENTRY_W-1:0] e);
        return (e[UOP_TYPE_MSB:UOP_TYPE_LSB] == '0) && (e[EXC_LSB +: EXC_W] == '0);
    endfunction

endpackage

// File: rtl/issue_queue_hazard.sv
// Decides whether the entry behind the head may dual-issue alongside the head.
module issue_queue_hazard
    import issue_queue_pkg::*;
(
    input  logic [REG_W-1:0] headRd_i,
    input  logic [EXC_W-1:0] headExc_i,
    input  logic [REG_W-1:0] nextRj_i,
    input  logic [REG_W-1:0] nextRk_i,
    input  logic [EXC_W-1:0] nextExc_i,
    input  logic             nextAlu_i,
    output logic             pairOk_o
);

    // r0 is never a real producer, so a head writing r0 creates no dependence
    logic noRaw;
    assign noRaw = (headRd_i == '0) || ((headRd_i != nextRj_i) && (headRd_i != nextRk_i));

    assign pairOk_o = nextAlu_i && (headExc_i == '0) && (nextExc_i == '0) && noRaw;

endmodule

// File: rtl/issue_queue.sv
// Circular in-order issue queue: accepts up to two decoded instructions per
// cycle and issues up to two to the execute units, oldest first.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = issue_queue_pkg::ENTRY_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [ENTRY_W-1:0]           in_entry0,
    input  logic [ENTRY_W-1:0]           in_entry1,
    input  logic                         has_interrupt,
    output logic [1:0]                   num_read,
    input  logic                         eu0_ready,
    input  logic                         eu1_ready,
    output logic                         eu0_en,
    output logic                         eu1_en,
    output logic [ENTRY_W-1:0]           eu0_entry,
    output logic [ENTRY_W-1:0]           eu1_entry,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   headNext, tailNext;
    logic               pairOk;
    logic [1:0]         issued, enqCnt;
    logic [OCC_W:0]     freeAfter;
    logic               keep0, keep1;
    logic [ENTRY_W-1:0] wrData0, wrData1;

    assign headNext  = head_q + PTR_W'(1);
    assign tailNext  = tail_q + PTR_W'(1);
    assign eu0_entry = mem_q[head_q];
    assign eu1_entry = mem_q[headNext];
    assign occupancy = occ_q;

    issue_queue_hazard uHazard (
        .headRd_i  (eu0_entry[RD_LSB +: REG_W]),
        .headExc_i (eu0_entry[EXC_LSB +: EXC_W]),
        .nextRj_i  (eu1_entry[RJ_LSB +: REG_W]),
        .nextRk_i  (eu1_entry[RK_LSB +: REG_W]),
        .nextExc_i (eu1_entry[EXC_LSB +: EXC_W]),
        .nextAlu_i (eu1_entry[ITYPE_IDX_ALU]),
        .pairOk_o  (pairOk)
    );

    assign eu0_en = (occ_q != '0) && eu0_ready && !flush;
    assign eu1_en = eu0_en && (occ_q >= OCC_W'(2)) && eu1_ready && pairOk;
    assign issued = {1'b0, eu0_en} + {1'b0, eu1_en};

    // Slots freed by this cycle's issue are already available to upstream
    assign freeAfter = (OCC_W+1)'(DEPTH) - {1'b0, occ_q} + (OCC_W+1)'(issued);

    always_comb begin
        if (rst) begin
            num_read = 2'b11;
        end else if (flush) begin
            num_read = 2'b00;
        end else if (freeAfter >= (OCC_W+1)'(2)) begin
            num_read = 2'b11;
        end else if (freeAfter == (OCC_W+1)'(1)) begin
            num_read = 2'b01;
        end else begin
            num_read = 2'b00;
        end
    end

    assign keep0  = num_read[0] && !isBubble(in_entry0);
    assign keep1  = num_read[1] && !isBubble(in_entry1);
    assign enqCnt = {1'b0, keep0} + {1'b0, keep1};

    // Bubbles are squeezed out, so the first kept entry always lands at tail
    // and is the one that carries a pending interrupt
    always_comb begin
        wrData0 = keep0 ? in_entry0 : in_entry1;
        wrData1 = in_entry1;
        if (has_interrupt) begin
            wrData0[EXC_LSB +: EXC_W] = EXP_INT;
        end
    end

    always_comb begin
        head_d = head_q + PTR_W'(issued);
        tail_d = tail_q + PTR_W'(enqCnt);
        occ_d  = occ_q - OCC_W'(issued) + OCC_W'(enqCnt);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enqCnt != 2'd0) begin
            mem_q[tail_q] <= wrData0;
        end
        if (enqCnt == 2'd2) begin
            mem_q[tailNext] <= wrData1;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomised scoreboard bench for issue_queue against a queue-based model of
// the issue, consume and enqueue rules.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);
    typedef logic [ENTRY_W-1:0] entry_t;

    logic             clk = 1'b0;
    logic             rst, flush, hasInt, eu0Ready, eu1Ready;
    entry_t           inEntry0, inEntry1;
    logic [1:0]       numRead;
    logic             eu0En, eu1En;
    entry_t           eu0Entry, eu1Entry;
    logic [OCC_W-1:0] occupancy;

    int     checks = 0;
    int     errors = 0;
    entry_t modelQ[$];

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_entry0     (inEntry0),
        .in_entry1     (inEntry1),
        .has_interrupt (hasInt),
        .num_read      (numRead),
        .eu0_ready     (eu0Ready),
        .eu1_ready     (eu1Ready),
        .eu0_en        (eu0En),
        .eu1_en        (eu1En),
        .eu0_entry     (eu0Entry),
        .eu1_entry     (eu1Entry),
        .occupancy     (occupancy)
    );

    function automatic entry_t makeEntry(input logic [3:0] itype, input logic [4:0] rd,
                                         input logic [4:0] rj, input logic [4:0] rk,
                                         input logic [6:0] exc);
        logic [3:0] opc;
        opc = 4'($urandom);
        return {32'($urandom), 32'($urandom), 32'($urandom), exc, 32'($urandom),
                rd, rk, rj, itype, opc};
    endfunction

    function automatic logic [6:0] excOf(input entry_t e);
        return e[EXC_LSB +: 7];
    endfunction

    function automatic bit bubbleOf(input entry_t e);
        return (e[7:4] == 4'd0) && (excOf(e) == 7'd0);
    endfunction

    function automatic bit pairAllowed(input entry_t h, input entry_t n);
        logic [4:0] hRd;
        hRd = h[RD_LSB +: 5];
        if (!n[ITYPE_IDX_ALU]) return 1'b0;
        if (excOf(h) != 7'd0 || excOf(n) != 7'd0) return 1'b0;
        if (hRd == 5'd0) return 1'b1;
        return (hRd != n[RJ_LSB +: 5]) && (hRd != n[RK_LSB +: 5]);
    endfunction

    task automatic checkOutput(input string name, input entry_t actual, input entry_t required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Model the cycle at the falling edge: check control outputs, pop the
    // scoreboard on each DUT strobe, then push whatever upstream hands over
    always @(negedge clk) begin
        int         occ, freeAfter;
        bit         expEn0, expEn1, stamped;
        logic [1:0] expNum;
        entry_t     e;
        if (rst) begin
            checkOutput("resetOcc", entry_t'(occupancy), '0);
            checkOutput("resetEn", entry_t'({eu0En, eu1En}), '0);
            checkOutput("resetNumRead", entry_t'(numRead), entry_t'(2'b11));
            modelQ.delete();
        end else begin
            occ = modelQ.size();
            expEn0 = (occ >= 1) && eu0Ready && !flush;
            expEn1 = expEn0 && (occ >= 2) && eu1Ready && pairAllowed(modelQ[0], modelQ[1]);
            freeAfter = DEPTH - occ + int'(expEn0) + int'(expEn1);
            expNum = flush ? 2'b00 : (freeAfter >= 2) ? 2'b11 : (freeAfter == 1) ? 2'b01 : 2'b00;
            checkOutput("occupancy", entry_t'(occupancy), entry_t'(occ));
            checkOutput("eu0En", entry_t'(eu0En), entry_t'(expEn0));
            checkOutput("eu1En", entry_t'(eu1En), entry_t'(expEn1));
            checkOutput("numRead", entry_t'(numRead), entry_t'(expNum));
            if (eu0En) begin
                if (modelQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL eu0Issue: actual=strobe required=empty queue");
                end else begin
                    e = modelQ.pop_front();
                    checkOutput("eu0Entry", eu0Entry, e);
                end
            end
            if (eu1En) begin
                if (modelQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL eu1Issue: actual=strobe required=empty queue");
                end else begin
                    e = modelQ.pop_front();
                    checkOutput("eu1Entry", eu1Entry, e);
                end
            end
            if (flush) begin
                modelQ.delete();
            end else begin
                stamped = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (expNum[s]) begin
                        e = (s == 0) ? inEntry0 : inEntry1;
                        if (!bubbleOf(e)) begin
                            if (hasInt && !stamped) e[EXC_LSB +: 7] = EXP_INT;
                            stamped = 1'b1;
                            modelQ.push_back(e);
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input entry_t e0, input entry_t e1, input logic intr,
                                 input logic r0, input logic r1, input logic fl);
        inEntry0 = e0;
        inEntry1 = e1;
        hasInt   = intr;
        eu0Ready = r0;
        eu1Ready = r1;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(makeEntry(4'd0, 5'd0, 5'd0, 5'd0, 7'd0),
                          makeEntry(4'd0, 5'd0, 5'd0, 5'd0, 7'd0), 1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic midReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstOcc", entry_t'(occupancy), '0);
        checkOutput("asyncRstEn", entry_t'({eu0En, eu1En}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic entry_t randEntry();
        logic [3:0] itype;
        logic [6:0] exc;
        itype = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        exc   = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
        return makeEntry(itype, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), exc);
    endfunction

    initial begin
        entry_t bub, alu;
        bub = makeEntry(4'd0, 5'd0, 5'd0, 5'd0, 7'd0);
        rst = 1'b1; flush = 1'b0; hasInt = 1'b0; eu0Ready = 1'b0; eu1Ready = 1'b0;
        inEntry0 = bub; inEntry1 = bub;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] independent ALU pair dual-issues");
        applyStimulus(makeEntry(4'd1, 5'd3, 5'd1, 5'd2, 7'd0),
                      makeEntry(4'd1, 5'd4, 5'd1, 5'd2, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(bub, bub, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(bub, bub, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] RAW dependence blocks second issue");
        applyStimulus(makeEntry(4'd1, 5'd5, 5'd1, 5'd2, 7'd0),
                      makeEntry(4'd1, 5'd6, 5'd5, 5'd2, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] full queue throttles upstream");
        alu = makeEntry(4'd2, 5'd1, 5'd0, 5'd0, 7'd0);
        applyStimulus(alu, makeEntry(4'd2, 5'd2, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeEntry(4'd2, 5'd3, 5'd0, 5'd0, 7'd0),
                      makeEntry(4'd2, 5'd4, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(randEntry(), randEntry(), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeEntry(4'd2, 5'd7, 5'd0, 5'd0, 7'd0), randEntry(), 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        $display("[TB] interrupt tags first real entry");
        applyStimulus(bub, makeEntry(4'd1, 5'd2, 5'd0, 5'd0, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeEntry(4'd1, 5'd2, 5'd0, 5'd0, 7'd0),
                      makeEntry(4'd1, 5'd3, 5'd0, 5'd0, 7'd0), 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] flush and asynchronous reset");
        applyStimulus(randEntry() | entry_t'(8'h10), makeEntry(4'd1, 5'd1, 5'd0, 5'd0, 7'd0),
                      1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(makeEntry(4'd1, 5'd1, 5'd0, 5'd0, 7'd0), bub, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(randEntry(), randEntry(), 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(makeEntry(4'd1, 5'd1, 5'd0, 5'd0, 7'd0),
                      makeEntry(4'd1, 5'd2, 5'd0, 5'd0, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        midReset();
        applyStimulus(makeEntry(4'd1, 5'd1, 5'd0, 5'd0, 7'd0), bub, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] randomised traffic with wrap-around");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) midReset();
            applyStimulus(randEntry(), randEntry(), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 31) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
